// File: rtl/qspi_rx_deserializer_pkg.sv
// Shared types and helpers for the QSPI read-data deserializer.
package qspi_pkg;

    typedef enum logic [1:0] {
        QSPI_SINGLE = 2'd0,
        QSPI_DUAL   = 2'd1,
        QSPI_QUAD   = 2'd2
    } qspi_mode_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_DONE  = 2'd2
    } rx_state_e;

    // The reserved encoding falls back to single-wire sampling.
    function automatic logic [2:0] bits_per_sample(input logic [1:0] mode);
        case (mode)
            QSPI_QUAD: return 3'd4;
            QSPI_DUAL: return 3'd2;
            default:   return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/qspi_rx_deserializer_if.sv
// Control, pin and word-stream signals between the SPI controller and the deserializer.
interface qspi_rx_deserializer_if #(
    parameter int WORD_W  = 32,
    parameter int LEN_W   = 16,
    parameter int BYTES_W = $clog2(WORD_W/8) + 1
);
    logic               start;
    logic [LEN_W-1:0]   xfer_len;
    logic [1:0]         mode;
    logic               sample_en;
    logic [3:0]         qspi_io;
    logic               hold_req;
    logic [WORD_W-1:0]  word_data;
    logic [BYTES_W-1:0] word_bytes;
    logic               word_valid;
    logic               word_ready;
    logic               busy;
    logic               done;
    logic               overflow;

    modport master (
        output start, xfer_len, mode, sample_en, qspi_io, word_ready,
        input  hold_req, word_data, word_bytes, word_valid, busy, done, overflow
    );

    modport slave (
        input  start, xfer_len, mode, sample_en, qspi_io, word_ready,
        output hold_req, word_data, word_bytes, word_valid, busy, done, overflow
    );
endinterface

// File: rtl/qspi_rx_deserializer_fifo.sv
// Synchronous show-ahead FIFO; push while full is accepted only alongside a pop.
module qspi_rx_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/qspi_rx_deserializer.sv
// QSPI read-data deserializer: packs 1/2/4-bit samples MSB-first into words and queues them.
module qspi_rx_deserializer
    import qspi_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    qspi_rx_deserializer_if.slave bus
);
    localparam int BYTES_W = $clog2(WORD_W/8) + 1;
    localparam int CNT_W   = $clog2(WORD_W) + 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    rx_state_e          state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [CNT_W-1:0]   bits_q, bits_d, bits_nxt;
    logic [WORD_W-1:0]  sreg_q, sreg_d, sreg_nxt;
    logic               ovf_q, ovf_d;

    logic               shifting, take, drop, byte_done, last_byte, push, pop;
    logic               fifo_full, fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;
    logic [BYTES_W-1:0] push_bytes;

    always_comb begin
        case (mode_q)
            QSPI_QUAD: sreg_nxt = {sreg_q[WORD_W-5:0], bus.qspi_io};
            QSPI_DUAL: sreg_nxt = {sreg_q[WORD_W-3:0], bus.qspi_io[1:0]};
            default:   sreg_nxt = {sreg_q[WORD_W-2:0], bus.qspi_io[1]};
        endcase
    end

    assign bits_nxt   = bits_q + CNT_W'(bits_per_sample(mode_q));
    assign shifting   = (state_q == RX_SHIFT);
    assign pop        = ~fifo_empty & bus.word_ready;
    // A sample that lands while full is still taken if the consumer frees a slot on that edge.
    assign take       = shifting & bus.sample_en & (~fifo_full | pop);
    assign drop       = shifting & bus.sample_en & fifo_full & ~pop;
    assign byte_done  = (bits_nxt[2:0] == 3'd0);
    assign last_byte  = byte_done & (left_q == LEN_W'(1));
    assign push       = take & ((bits_nxt == CNT_W'(WORD_W)) | last_byte);
    assign push_bytes = BYTES_W'(bits_nxt >> 3);

    assign bus.hold_req = fifo_full | ((fifo_count == FCNT_W'(FIFO_DEPTH-1)) & push);
    assign bus.busy     = shifting;
    assign bus.done     = (state_q == RX_DONE);
    assign bus.overflow = ovf_q;
    assign bus.word_valid = ~fifo_empty;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        left_d  = left_q;
        bits_d  = bits_q;
        sreg_d  = sreg_q;
        ovf_d   = ovf_q | drop;
        case (state_q)
            RX_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    left_d  = bus.xfer_len;
                    bits_d  = '0;
                    sreg_d  = '0;
                    state_d = (bus.xfer_len == '0) ? RX_DONE : RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (take) begin
                    // Clearing on push keeps a short final word right-aligned with zero upper bytes.
                    sreg_d = push ? '0 : sreg_nxt;
                    bits_d = push ? '0 : bits_nxt;
                    if (byte_done) left_d = left_q - 1'b1;
                    if (last_byte) state_d = RX_DONE;
                end
            end
            RX_DONE: state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            mode_q  <= 2'd0;
            left_q  <= '0;
            bits_q  <= '0;
            sreg_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            left_q  <= left_d;
            bits_q  <= bits_d;
            sreg_q  <= sreg_d;
            ovf_q   <= ovf_d;
        end
    end

    qspi_rx_fifo #(.WIDTH(WORD_W + BYTES_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({push_bytes, sreg_nxt}),
        .pop_i   (pop),
        .rdata_o ({bus.word_bytes, bus.word_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
endmodule

// File: tb/tb_qspi_rx_deserializer.sv
// Directed bench for the QSPI deserializer with a 2-entry FIFO to exercise back-pressure.
module tb_qspi_rx_deserializer;
    import qspi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qspi_rx_deserializer_if #(.WORD_W(32), .LEN_W(16)) bus ();

    qspi_rx_deserializer #(.WORD_W(32), .FIFO_DEPTH(2), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [15:0] len, input logic [1:0] m);
        bus.start    = 1'b1;
        bus.xfer_len = len;
        bus.mode     = m;
        tick();
        bus.start    = 1'b0;
    endtask

    // Behaves like the SCLK generator: never issues a sample while hold_req is up.
    task automatic sample(input logic [3:0] io);
        int w = 0;
        while (bus.hold_req && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk("hold_stuck", 64'd1, 64'd0);
        bus.sample_en = 1'b1;
        bus.qspi_io   = io;
        tick();
        bus.sample_en = 1'b0;
    endtask

    task automatic pop_word(input string tag, input logic [31:0] d, input logic [2:0] b);
        chk({tag, "_valid"}, bus.word_valid, 1);
        chk({tag, "_data"}, bus.word_data, d);
        chk({tag, "_bytes"}, bus.word_bytes, b);
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_valid"}, bus.word_valid, 0);
        chk({tag, "_hold"}, bus.hold_req, 0);
        chk({tag, "_ovf"}, bus.overflow, 0);
        chk({tag, "_data"}, bus.word_data, 0);
        chk({tag, "_bytes"}, bus.word_bytes, 0);
    endtask

    initial begin
        logic [7:0]  pat8;
        logic [47:0] pat48;

        rst = 1'b1;
        bus.start = 1'b0; bus.xfer_len = '0; bus.mode = 2'd0;
        bus.sample_en = 1'b0; bus.qspi_io = 4'h0; bus.word_ready = 1'b0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // quad, one full word
        start_xfer(16'd4, QSPI_QUAD);
        chk("quad_busy", bus.busy, 1);
        for (int i = 0; i < 8; i++) sample(4'(i));
        chk("quad_done", bus.done, 1);
        chk("quad_busy_end", bus.busy, 0);
        pop_word("quad", 32'h0123_4567, 3'd4);
        chk("quad_done_clr", bus.done, 0);

        // single wire on io1; io0 carries the inverse to catch a wrong pin
        pat8 = 8'hA5;
        start_xfer(16'd1, QSPI_SINGLE);
        for (int i = 7; i >= 0; i--) sample({2'b00, pat8[i], ~pat8[i]});
        pop_word("single", 32'h0000_00A5, 3'd1);

        // reserved mode behaves as single
        pat8 = 8'h3C;
        start_xfer(16'd1, 2'd3);
        for (int i = 7; i >= 0; i--) sample({2'b11, pat8[i], ~pat8[i]});
        pop_word("mode3", 32'h0000_003C, 3'd1);

        // dual, full word then a 2-byte partial; io3:2 carry junk
        pat48 = 48'hDEAD_BEEF_CAFE;
        start_xfer(16'd6, QSPI_DUAL);
        for (int k = 0; k < 24; k++) sample({2'b10, pat48[47-2*k -: 2]});
        chk("dual_done", bus.done, 1);
        chk("dual_busy", bus.busy, 0);
        pop_word("dual_w0", 32'hDEAD_BEEF, 3'd4);
        pop_word("dual_w1", 32'h0000_CAFE, 3'd2);
        chk("dual_empty", bus.word_valid, 0);

        // back-pressure: two words fill the FIFO
        start_xfer(16'd16, QSPI_QUAD);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) sample(4'(9*k + i));
        chk("bp_hold", bus.hold_req, 1);
        chk("bp_ovf_pre", bus.overflow, 0);
        bus.sample_en = 1'b1;
        bus.qspi_io   = 4'hF;
        tick();
        bus.sample_en = 1'b0;
        chk("bp_ovf", bus.overflow, 1);
        pop_word("bp_w0", 32'h0123_4567, 3'd4);
        for (int i = 0; i < 8; i++) sample(4'(18 + i));
        pop_word("bp_w1", 32'h9ABC_DEF0, 3'd4);
        for (int i = 0; i < 8; i++) sample(4'(27 + i));
        chk("bp_done", bus.done, 1);
        pop_word("bp_w2", 32'h2345_6789, 3'd4);
        pop_word("bp_w3", 32'hBCDE_F012, 3'd4);
        chk("bp_empty", bus.word_valid, 0);
        chk("bp_ovf_sticky", bus.overflow, 1);

        // reset mid-transfer with a word already queued
        start_xfer(16'd8, QSPI_QUAD);
        for (int i = 0; i < 8; i++) sample(4'(i));
        for (int i = 0; i < 3; i++) sample(4'hA);
        chk("rst_pre_valid", bus.word_valid, 1);
        rst = 1'b1;
        tick();
        chk_idle_outputs("midrst");
        rst = 1'b0;
        tick();
        start_xfer(16'd4, QSPI_QUAD);
        for (int i = 0; i < 8; i++) sample(4'(15 - i));
        pop_word("post_rst", 32'hFEDC_BA98, 3'd4);

        // zero-length transfer
        start_xfer(16'd0, QSPI_QUAD);
        chk("len0_done", bus.done, 1);
        chk("len0_busy", bus.busy, 0);
        tick();
        chk("len0_done_clr", bus.done, 0);
        chk("len0_novalid", bus.word_valid, 0);

        // start while busy is ignored
        start_xfer(16'd4, QSPI_QUAD);
        sample(4'h0);
        sample(4'h1);
        start_xfer(16'd1, QSPI_SINGLE);
        chk("restart_busy", bus.busy, 1);
        for (int i = 2; i < 7; i++) sample(4'(i));
        chk("restart_notdone", bus.done, 0);
        sample(4'h7);
        chk("restart_done", bus.done, 1);
        tick();
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        chk("idle_sample_noflag", bus.overflow, 0);
        pop_word("restart", 32'h0123_4567, 3'd4);
        chk("restart_empty", bus.word_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
